// File: rtl/cursor_step_ctrl.sv
// Cursor up/down pushbutton conditioner: two-flop sync, per-button debounce,
// then single-cycle step pulses with hold-to-auto-repeat. Up and down are
// mutually exclusive; pressing both locks out all stepping until both release.
module cursor_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic clk_fpga,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_down,
    output logic step_up,
    output logic step_down,
    output logic up_held,
    output logic down_held
);

    localparam int unsigned CntW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TimerMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);

    localparam logic [CntW-1:0]   CntLast     = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TimerW-1:0] TimerDelay  = TimerW'(REPEAT_DELAY);
    localparam logic [TimerW-1:0] TimerPeriod = TimerW'(REPEAT_PERIOD);
    localparam logic [TimerW-1:0] TimerOne    = TimerW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat,
        StLockout
    } state_e;

    // Index 0 is the up button, index 1 the down button.
    logic [1:0] btn_raw;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] stable_q, stable_d;
    logic [1:0] held_q;
    logic [1:0][CntW-1:0] cnt_q, cnt_d;

    state_e              state_q, state_d;
    logic                dir_q, dir_d;        // latched direction: 0 = up, 1 = down
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                step_up_q, step_up_d;
    logic                step_down_q, step_down_d;
    logic                latched_lvl;
    logic                other_lvl;
    logic                expire;

    assign btn_raw = {btn_down, btn_up};

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: stable flips only after the synced level has differed long enough.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Debounce state plus registered copy of the stable levels.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            cnt_q    <= '0;
            held_q   <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            held_q   <= stable_q;
        end
    end

    // Step FSM next-state, shared repeat timer and pulse requests.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        timer_d     = timer_q;
        step_up_d   = 1'b0;
        step_down_d = 1'b0;
        latched_lvl = dir_q ? held_q[1] : held_q[0];
        other_lvl   = dir_q ? held_q[0] : held_q[1];
        expire      = (timer_q == TimerOne);

        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (held_q[0] && held_q[1]) begin
                    state_d = StLockout;
                end else if (held_q[0]) begin
                    step_up_d = 1'b1;
                    dir_d     = 1'b0;
                    timer_d   = TimerDelay;
                    state_d   = StDelay;
                end else if (held_q[1]) begin
                    step_down_d = 1'b1;
                    dir_d       = 1'b1;
                    timer_d     = TimerDelay;
                    state_d     = StDelay;
                end
            end
            StDelay, StRepeat: begin
                if (!latched_lvl) begin
                    timer_d = '0;
                    state_d = StIdle;
                end else if (other_lvl) begin
                    // Conflict beats a same-cycle expiry.
                    timer_d = '0;
                    state_d = StLockout;
                end else if (expire) begin
                    step_up_d   = ~dir_q;
                    step_down_d = dir_q;
                    timer_d     = TimerPeriod;
                    state_d     = StRepeat;
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end
            StLockout: begin
                timer_d = '0;
                if (held_q == 2'b00) begin
                    state_d = StIdle;
                end
            end
            default: begin
                timer_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, timer and registered step outputs.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            dir_q       <= 1'b0;
            timer_q     <= '0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            timer_q     <= timer_d;
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
        end
    end

    assign step_up   = step_up_q;
    assign step_down = step_down_q;
    assign up_held   = held_q[0];
    assign down_held = held_q[1];

endmodule

// File: tb/tb_cursor_step_ctrl.sv
// Bench for cursor_step_ctrl with small debounce/repeat parameters. Expected
// step pulses (direction and edge number) are queued as stimulus is applied
// and a negedge monitor pops and compares them as pulses appear.
module tb_cursor_step_ctrl;

    localparam int unsigned Deb = 4;
    localparam int unsigned RDelay = 20;
    localparam int unsigned RPeriod = 5;

    // Raw rise sampled at edge k: held at k+2+Deb, step pulse registered at k+3+Deb.
    localparam int PulseLat = 3 + Deb;
    localparam int HeldLat  = 2 + Deb;

    typedef struct {
        bit up;
        int cyc;
    } exp_t;

    logic clk_fpga = 1'b0;
    logic rst_n    = 1'b1;
    logic btn_up   = 1'b0;
    logic btn_down = 1'b0;
    logic step_up, step_down, up_held, down_held;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    cursor_step_ctrl #(
        .DEBOUNCE_CYCLES (Deb),
        .REPEAT_DELAY    (RDelay),
        .REPEAT_PERIOD   (RPeriod)
    ) dut (
        .clk_fpga  (clk_fpga),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .step_up   (step_up),
        .step_down (step_down),
        .up_held   (up_held),
        .down_held (down_held)
    );

    always #5 clk_fpga = ~clk_fpga;

    // Edge counter: value seen at a negedge is the index of the preceding posedge.
    always @(posedge clk_fpga) cyc <= cyc + 1;

    // Scoreboard monitor for step pulses.
    always @(negedge clk_fpga) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missed_pulse: expected %s pulse at edge %0d, no pulse observed (now %0d)",
                     e.up ? "up" : "down", e.cyc, cyc);
        end
        if (step_up || step_down) begin
            n_checks++;
            if (step_up && step_down) begin
                n_fail++;
                $display("FAIL exclusive_steps: edge %0d step_up=1 step_down=1, required not both",
                         cyc);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: edge %0d step_up=%0b step_down=%0b, none expected",
                         cyc, step_up, step_down);
            end else begin
                e = exp_q.pop_front();
                if (e.up !== step_up || e.cyc !== cyc) begin
                    n_fail++;
                    $display("FAIL pulse_match: got up=%0b at edge %0d, required up=%0b at edge %0d",
                             step_up, cyc, e.up, e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input bit up, input int at);
        exp_t e;
        e.up  = up;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk_fpga);
    endtask

    task automatic check_queue_empty(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected pulses outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        int c0, p;
        rst_n    = 1'b0;
        btn_up   = 1'b1;
        btn_down = 1'b0;
        repeat (5) @(negedge clk_fpga);
        n_checks += 4;
        if (step_up !== 1'b0) begin
            n_fail++; $display("FAIL reset_step_up: got %b, required 0", step_up);
        end
        if (step_down !== 1'b0) begin
            n_fail++; $display("FAIL reset_step_down: got %b, required 0", step_down);
        end
        if (up_held !== 1'b0) begin
            n_fail++; $display("FAIL reset_up_held: got %b, required 0", up_held);
        end
        if (down_held !== 1'b0) begin
            n_fail++; $display("FAIL reset_down_held: got %b, required 0", down_held);
        end
        // Release with the button already held: first sampling edge is c0+1.
        c0 = cyc;
        p  = c0 + 1 + PulseLat;
        rst_n = 1'b1;
        push_exp(1'b1, p);
        push_exp(1'b1, p + RDelay);
        push_exp(1'b1, p + RDelay + RPeriod);
        wait_until(p + RDelay + RPeriod + 2);
        // Asynchronous reset in the middle of auto-repeat.
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (up_held !== 1'b0) begin
            n_fail++; $display("FAIL midrepeat_reset_held: got %b, required 0", up_held);
        end
        if (step_up !== 1'b0) begin
            n_fail++; $display("FAIL midrepeat_reset_step: got %b, required 0", step_up);
        end
        btn_up = 1'b0;
        repeat (3) @(negedge clk_fpga);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_fpga);
        check_queue_empty("reset_pending");
    endtask

    task automatic test_short_press();
        int c, rise_c, fall_c;
        logic prev;
        c      = cyc;
        rise_c = -1;
        fall_c = -1;
        prev   = up_held;
        btn_up = 1'b1;
        push_exp(1'b1, c + 1 + PulseLat);
        for (int i = 0; i < 40; i++) begin
            if (i == 12) btn_up = 1'b0;
            @(negedge clk_fpga);
            if (up_held && !prev) rise_c = cyc;
            if (!up_held && prev) fall_c = cyc;
            prev = up_held;
        end
        n_checks += 2;
        if (rise_c != c + 1 + HeldLat) begin
            n_fail++;
            $display("FAIL short_held_rise: edge %0d, required %0d", rise_c, c + 1 + HeldLat);
        end
        if (fall_c != c + 13 + HeldLat) begin
            n_fail++;
            $display("FAIL short_held_fall: edge %0d, required %0d", fall_c, c + 13 + HeldLat);
        end
        check_queue_empty("short_pending");
    endtask

    task automatic test_bounce();
        int c, rises, rise_c;
        logic prev;
        c      = cyc;
        rises  = 0;
        rise_c = -1;
        prev   = down_held;
        // Final rise is driven at iteration 20 (sampled at edge c+21).
        push_exp(1'b0, c + 21 + PulseLat);
        for (int i = 0; i < 45; i++) begin
            if (i < 20)      btn_down = ((i / 2) % 2 == 0);
            else if (i < 36) btn_down = 1'b1;
            else             btn_down = 1'b0;
            @(negedge clk_fpga);
            if (down_held && !prev) begin
                rises++;
                rise_c = cyc;
            end
            prev = down_held;
        end
        repeat (10) @(negedge clk_fpga);
        n_checks += 2;
        if (rises != 1) begin
            n_fail++; $display("FAIL bounce_rise_count: got %0d, required 1", rises);
        end
        if (rise_c != c + 21 + HeldLat) begin
            n_fail++;
            $display("FAIL bounce_rise_edge: edge %0d, required %0d", rise_c, c + 21 + HeldLat);
        end
        check_queue_empty("bounce_pending");
    endtask

    task automatic test_auto_repeat();
        int c, p;
        c = cyc;
        p = c + 1 + PulseLat;
        btn_up = 1'b1;
        push_exp(1'b1, p);
        // Released at negedge p+60: sampled p+61, held drops at p+67.
        for (int t = p + RDelay; t <= p + 61 + HeldLat; t += RPeriod) push_exp(1'b1, t);
        wait_until(p + 60);
        btn_up = 1'b0;
        wait_until(p + 90);
        check_queue_empty("repeat_pending");
        n_checks++;
        if (up_held !== 1'b0) begin
            n_fail++; $display("FAIL repeat_held_after: got %b, required 0", up_held);
        end
    endtask

    task automatic test_conflict();
        int c, p;
        c = cyc;
        p = c + 1 + PulseLat;
        btn_up = 1'b1;
        push_exp(1'b1, p);
        push_exp(1'b1, p + RDelay);
        // Down debounces after the p+25 expiry, so that one repeat still fires.
        push_exp(1'b1, p + RDelay + RPeriod);
        wait_until(p + 21);
        btn_down = 1'b1;
        wait_until(p + 40);
        n_checks++;
        if (down_held !== 1'b1 || up_held !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_both_held: up=%b down=%b, required 1 1", up_held, down_held);
        end
        wait_until(p + 50);
        btn_up = 1'b0;
        wait_until(p + 60);
        btn_down = 1'b0;
        wait_until(p + 75);
        check_queue_empty("conflict_pending");
        btn_down = 1'b1;
        push_exp(1'b0, p + 76 + PulseLat);
        wait_until(p + 90);
        btn_down = 1'b0;
        wait_until(p + 110);
        check_queue_empty("conflict_repress");
    endtask

    task automatic test_simultaneous();
        int c, c2;
        c = cyc;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        wait_until(c + 30);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_until(c + 50);
        check_queue_empty("simul_pending");
        n_checks++;
        if (up_held !== 1'b0 || down_held !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_released: up=%b down=%b, required 0 0", up_held, down_held);
        end
        // A fresh press proves the FSM left lockout.
        c2 = cyc;
        btn_up = 1'b1;
        push_exp(1'b1, c2 + 1 + PulseLat);
        wait_until(c2 + 14);
        btn_up = 1'b0;
        wait_until(c2 + 30);
        check_queue_empty("simul_after");
    endtask

    initial begin
        #1;
        test_reset();
        test_short_press();
        test_bounce();
        test_auto_repeat();
        test_conflict();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
